// File: rtl/coco_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// coco_ram_arbiter_if
// Bundles every signal between the RAM arbiter, its three requesters
// (VDG display fetch, 6809 CPU, ioctl loader) and the single-port RAM macro.
//
//   VDG    : vdg_req, vdg_addr -> ; <- vdg_dout, vdg_ack
//   CPU    : cpu_req, cpu_we, cpu_addr, cpu_din -> ; <- cpu_dout, cpu_ack
//   Loader : ld_req (level), ld_addr, ld_din -> ; <- ld_ack
//   RAM    : <- ram_addr, ram_din, ram_we ; ram_dout -> (1-cycle read latency)
//   Status : <- overrun (sticky)
//
// Modports:
//   slave  - the arbiter itself
//   master - the requester/RAM side (SAM/CPU/VDG glue, RAM model)
// ---------------------------------------------------------------------------
interface coco_ram_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              vdg_req;
    logic [ADDR_W-1:0] vdg_addr;
    logic [7:0]        vdg_dout;
    logic              vdg_ack;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_din;
    logic [7:0]        cpu_dout;
    logic              cpu_ack;

    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_din;
    logic              ld_ack;

    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic              ram_we;
    logic [7:0]        ram_dout;

    logic              overrun;

    modport slave (
        input  vdg_req, vdg_addr,
        output vdg_dout, vdg_ack,
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack,
        input  ld_req, ld_addr, ld_din,
        output ld_ack,
        output ram_addr, ram_din, ram_we,
        input  ram_dout,
        output overrun
    );

    modport master (
        output vdg_req, vdg_addr,
        input  vdg_dout, vdg_ack,
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack,
        output ld_req, ld_addr, ld_din,
        input  ld_ack,
        input  ram_addr, ram_din, ram_we,
        output ram_dout,
        input  overrun
    );
endinterface

// File: rtl/coco_ram_arbiter.sv
// ---------------------------------------------------------------------------
// coco_ram_arbiter
// Time-shares the single-port 64Kx8 system RAM between VDG display fetch,
// 6809 CPU accesses and the ioctl loader. One RAM access takes two clocks
// (ACCESS, DATA); a pending request is granted in DATA so accesses run
// back-to-back at full load.
//
// Priority at each grant point:
//   VDG > loader (only once starved) > CPU > loader
// The loader is starved after STARVE_MAX CPU grants taken while it was
// eligible; it then outranks the CPU for one grant.
//
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high; abandons any access in flight
//   bus    coco_ram_arbiter_if.slave - requester, RAM and status signals
//
// Parameters:
//   ADDR_W      RAM address width
//   STARVE_MAX  CPU grants the loader may lose before it outranks the CPU (1..15)
// ---------------------------------------------------------------------------
module coco_ram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             reset,
    coco_ram_arbiter_if.slave bus
);
    // VDG and CPU share one pulse-capture structure; loader is a level request.
    localparam int NCH    = 2;
    localparam int CH_VDG = 0;
    localparam int CH_CPU = 1;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DATA} state_t;
    typedef enum logic [1:0] {OWN_VDG, OWN_CPU, OWN_LD} owner_t;

    // ---------------- request channels ----------------
    logic [NCH-1:0]    chan_req;
    logic [ADDR_W-1:0] chan_addr [NCH];
    logic              chan_we   [NCH];
    logic [7:0]        chan_din  [NCH];

    assign chan_req[CH_VDG]  = bus.vdg_req;
    assign chan_addr[CH_VDG] = bus.vdg_addr;
    assign chan_we[CH_VDG]   = 1'b0;
    assign chan_din[CH_VDG]  = 8'h00;

    assign chan_req[CH_CPU]  = bus.cpu_req;
    assign chan_addr[CH_CPU] = bus.cpu_addr;
    assign chan_we[CH_CPU]   = bus.cpu_we;
    assign chan_din[CH_CPU]  = bus.cpu_din;

    logic [NCH-1:0]    pend;
    logic [ADDR_W-1:0] pend_addr [NCH];
    logic              pend_we   [NCH];
    logic [7:0]        pend_din  [NCH];
    logic [NCH-1:0]    grant_chan;
    logic [NCH-1:0]    overrun_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            logic              ch_pend_reg;
            logic [ADDR_W-1:0] ch_addr_reg;
            logic              ch_we_reg;
            logic [7:0]        ch_din_reg;

            // A new request always wins over the grant-clear, so a request
            // arriving in its own grant cycle is kept, and a request arriving
            // while still pending replaces the older one.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ch_pend_reg <= 1'b0;
                    ch_addr_reg <= '0;
                    ch_we_reg   <= 1'b0;
                    ch_din_reg  <= 8'h00;
                end else if (chan_req[gi]) begin
                    ch_pend_reg <= 1'b1;
                    ch_addr_reg <= chan_addr[gi];
                    ch_we_reg   <= chan_we[gi];
                    ch_din_reg  <= chan_din[gi];
                end else if (grant_chan[gi]) begin
                    ch_pend_reg <= 1'b0;
                end
            end

            assign pend[gi]        = ch_pend_reg;
            assign pend_addr[gi]   = ch_addr_reg;
            assign pend_we[gi]     = ch_we_reg;
            assign pend_din[gi]    = ch_din_reg;
            assign overrun_hit[gi] = chan_req[gi] && ch_pend_reg && !grant_chan[gi];
        end
    endgenerate

    // ---------------- arbitration ----------------
    state_t      state_reg;
    owner_t      owner_reg;
    logic        owner_we_reg;
    logic [3:0]  starve_cnt_reg;
    logic        overrun_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [7:0]  ram_din_reg;
    logic        ram_we_reg;
    logic        vdg_ack_reg;
    logic        cpu_ack_reg;
    logic        ld_ack_reg;
    logic [7:0]  vdg_dout_reg;
    logic [7:0]  cpu_dout_reg;

    logic        ld_in_flight;
    logic        ld_elig;
    logic        starved;
    logic        grant_ld;
    logic        any_grant;

    // The ack cycle is excluded so the same loader word is never written twice
    // while ld_req is still high from the previous transfer.
    assign ld_in_flight = (state_reg != S_IDLE) && (owner_reg == OWN_LD);
    assign ld_elig      = bus.ld_req && !ld_in_flight && !ld_ack_reg;
    assign starved      = (starve_cnt_reg == STARVE_LIM);

    always_comb begin
        grant_chan = '0;
        grant_ld   = 1'b0;
        if (state_reg == S_IDLE || state_reg == S_DATA) begin
            if (pend[CH_VDG])
                grant_chan[CH_VDG] = 1'b1;
            else if (ld_elig && starved)
                grant_ld = 1'b1;
            else if (pend[CH_CPU])
                grant_chan[CH_CPU] = 1'b1;
            else if (ld_elig)
                grant_ld = 1'b1;
        end
    end

    assign any_grant = (|grant_chan) || grant_ld;

    // Winner's access parameters.
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_din;
    logic              sel_we;
    owner_t            sel_owner;

    always_comb begin
        sel_addr  = bus.ld_addr;
        sel_din   = bus.ld_din;
        sel_we    = 1'b1;
        sel_owner = OWN_LD;
        for (int c = 0; c < NCH; c++) begin
            if (grant_chan[c]) begin
                sel_addr = pend_addr[c];
                sel_din  = pend_din[c];
                sel_we   = pend_we[c];
            end
        end
        if (grant_chan[CH_VDG])
            sel_owner = OWN_VDG;
        else if (grant_chan[CH_CPU])
            sel_owner = OWN_CPU;
    end

    // ---------------- access FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            owner_reg    <= OWN_VDG;
            owner_we_reg <= 1'b0;
            ram_addr_reg <= '0;
            ram_din_reg  <= 8'h00;
            ram_we_reg   <= 1'b0;
            vdg_ack_reg  <= 1'b0;
            cpu_ack_reg  <= 1'b0;
            ld_ack_reg   <= 1'b0;
            vdg_dout_reg <= 8'h00;
            cpu_dout_reg <= 8'h00;
        end else begin
            vdg_ack_reg <= 1'b0;
            cpu_ack_reg <= 1'b0;
            ld_ack_reg  <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    state_reg <= S_IDLE;
                end
                S_ACCESS: begin
                    // RAM samples address/data on this edge.
                    ram_we_reg <= 1'b0;
                    state_reg  <= S_DATA;
                end
                S_DATA: begin
                    // ram_dout now carries the word addressed in ACCESS.
                    case (owner_reg)
                        OWN_VDG: begin
                            vdg_ack_reg  <= 1'b1;
                            vdg_dout_reg <= bus.ram_dout;
                        end
                        OWN_CPU: begin
                            cpu_ack_reg <= 1'b1;
                            if (!owner_we_reg)
                                cpu_dout_reg <= bus.ram_dout;
                        end
                        default: begin
                            ld_ack_reg <= 1'b1;
                        end
                    endcase
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase

            // Grants happen in IDLE or DATA only; overrides the state above.
            if (any_grant) begin
                owner_reg    <= sel_owner;
                owner_we_reg <= sel_we;
                ram_addr_reg <= sel_addr;
                ram_din_reg  <= sel_din;
                ram_we_reg   <= sel_we;
                state_reg    <= S_ACCESS;
            end
        end
    end

    // ---------------- loader starvation counter ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_reg <= 4'd0;
        end else if (!bus.ld_req || grant_ld) begin
            starve_cnt_reg <= 4'd0;
        end else if (ld_elig && grant_chan[CH_CPU] && !starved) begin
            starve_cnt_reg <= starve_cnt_reg + 4'd1;
        end
    end

    // ---------------- sticky overrun ----------------
    always_ff @(posedge clk) begin
        if (reset)
            overrun_reg <= 1'b0;
        else if (|overrun_hit)
            overrun_reg <= 1'b1;
    end

    assign bus.ram_addr = ram_addr_reg;
    assign bus.ram_din  = ram_din_reg;
    assign bus.ram_we   = ram_we_reg;
    assign bus.vdg_ack  = vdg_ack_reg;
    assign bus.cpu_ack  = cpu_ack_reg;
    assign bus.ld_ack   = ld_ack_reg;
    assign bus.vdg_dout = vdg_dout_reg;
    assign bus.cpu_dout = cpu_dout_reg;
    assign bus.overrun  = overrun_reg;
endmodule

// File: tb/tb_coco_ram_arbiter.sv
`timescale 1ns/1ps
module tb_coco_ram_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    coco_ram_arbiter_if #(.ADDR_W(16)) bus ();

    coco_ram_arbiter #(.ADDR_W(16), .STARVE_MAX(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Synchronous RAM model, 1-cycle read latency.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitors: record acks and writes (owned by this block only).
    int vdg_ack_cnt = 0, cpu_ack_cnt = 0, ld_ack_cnt = 0;
    int cpu_ack_cyc = 0, vdg_ack_cyc = 0, ld_ack_cyc = 0;
    int vdg_ack_log [512];
    int watch_cnt = 0;
    logic [15:0] watch_addr = 16'h0000;
    always @(negedge clk) begin
        if (bus.vdg_ack) begin
            if (vdg_ack_cnt < 512) vdg_ack_log[vdg_ack_cnt] = cyc;
            vdg_ack_cnt++;
            vdg_ack_cyc = cyc;
        end
        if (bus.cpu_ack) begin cpu_ack_cnt++; cpu_ack_cyc = cyc; end
        if (bus.ld_ack)  begin ld_ack_cnt++;  ld_ack_cyc  = cyc; end
        if (bus.ram_we && bus.ram_addr == watch_addr) watch_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // One isolated CPU access; waits a fixed window and reports ack count/latency.
    task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] din,
                              output int lat, output int nacks);
        int base, t0;
        base = cpu_ack_cnt;
        t0 = cyc;
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_din = din;
        step();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        repeat (9) step();
        @(negedge clk);
        nacks = cpu_ack_cnt - base;
        lat = cpu_ack_cyc - t0;
        step();
    endtask

    task automatic test_reset();
        int base;
        reset = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0F0F; bus.cpu_din = 8'hEE;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 16'h0000 || bus.ram_din !== 8'h00) begin
            failures++;
            $display("FAIL reset_ram: we=%b addr=%h din=%h required 0/0000/00", bus.ram_we, bus.ram_addr, bus.ram_din);
        end
        checks++;
        if ({bus.vdg_ack, bus.cpu_ack, bus.ld_ack} !== 3'b000) begin
            failures++;
            $display("FAIL reset_acks: got %b required 000", {bus.vdg_ack, bus.cpu_ack, bus.ld_ack});
        end
        checks++;
        if (bus.vdg_dout !== 8'h00 || bus.cpu_dout !== 8'h00 || bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_outs: vdg_dout=%h cpu_dout=%h overrun=%b required 00/00/0", bus.vdg_dout, bus.cpu_dout, bus.overrun);
        end
        step();
        base = cpu_ack_cnt;
        reset = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        repeat (8) step();
        checks++;
        if (cpu_ack_cnt - base !== 0) begin
            failures++;
            $display("FAIL reset_no_capture: cpu acks=%0d required 0", cpu_ack_cnt - base);
        end
        $display("test_reset done");
    endtask

    task automatic test_cpu_write_read();
        int lat, n;
        do_reset();
        cpu_access(1'b1, 16'h0400, 8'hA5, lat, n);
        checks++;
        if (n !== 1 || lat !== 4) begin
            failures++;
            $display("FAIL cpu_write_lat: acks=%0d lat=%0d required 1/4", n, lat);
        end
        checks++;
        if (bus.cpu_dout !== 8'h00) begin
            failures++;
            $display("FAIL cpu_write_dout: got %h required 00", bus.cpu_dout);
        end
        cpu_access(1'b0, 16'h0400, 8'h00, lat, n);
        checks++;
        if (n !== 1 || lat !== 4) begin
            failures++;
            $display("FAIL cpu_read_lat: acks=%0d lat=%0d required 1/4", n, lat);
        end
        checks++;
        if (bus.cpu_dout !== 8'hA5) begin
            failures++;
            $display("FAIL cpu_read_data: got %h required a5", bus.cpu_dout);
        end
        cpu_access(1'b1, 16'h1234, 8'h3C, lat, n);
        checks++;
        if (n !== 1 || bus.cpu_dout !== 8'hA5) begin
            failures++;
            $display("FAIL cpu_write2: acks=%0d dout=%h required 1/a5", n, bus.cpu_dout);
        end
        $display("test_cpu_write_read done");
    endtask

    task automatic test_vdg_cpu_same();
        int t0;
        do_reset();
        t0 = cyc;
        bus.vdg_req = 1'b1; bus.vdg_addr = 16'h1234;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0400;
        step();
        bus.vdg_req = 1'b0; bus.cpu_req = 1'b0;
        repeat (10) step();
        @(negedge clk);
        checks++;
        if (vdg_ack_cyc - t0 !== 4) begin
            failures++;
            $display("FAIL same_vdg_lat: got %0d required 4", vdg_ack_cyc - t0);
        end
        checks++;
        if (cpu_ack_cyc - t0 !== 6) begin
            failures++;
            $display("FAIL same_cpu_lat: got %0d required 6", cpu_ack_cyc - t0);
        end
        checks++;
        if (bus.vdg_dout !== 8'h3C || bus.cpu_dout !== 8'hA5) begin
            failures++;
            $display("FAIL same_data: vdg=%h cpu=%h required 3c/a5", bus.vdg_dout, bus.cpu_dout);
        end
        step();
        $display("test_vdg_cpu_same done");
    endtask

    task automatic test_starve();
        int t0, cbase, lbase, wbase, cpu_before;
        logic seen;
        do_reset();
        watch_addr = 16'h3000;
        step();
        cbase = cpu_ack_cnt; lbase = ld_ack_cnt; wbase = watch_cnt;
        cpu_before = -1;
        seen = 1'b0;
        t0 = cyc;
        bus.ld_addr = 16'h3000; bus.ld_din = 8'h99;
        for (int k = 0; k < 40; k++) begin
            bus.cpu_req = (k % 2 == 0) && (k < 24);
            bus.cpu_we = 1'b0;
            bus.cpu_addr = 16'h0400;
            bus.ld_req = (k >= 1) && !seen;
            @(negedge clk);
            if (bus.ld_ack && !seen) seen = 1'b1;
            step();
            if (seen && cpu_before < 0) cpu_before = cpu_ack_cnt - cbase;
        end
        bus.cpu_req = 1'b0; bus.ld_req = 1'b0;
        checks++;
        if (cpu_before !== 8) begin
            failures++;
            $display("FAIL starve_cpu_grants: got %0d required 8", cpu_before);
        end
        checks++;
        if (ld_ack_cyc - t0 !== 20) begin
            failures++;
            $display("FAIL starve_ld_ack_cycle: got %0d required 20", ld_ack_cyc - t0);
        end
        checks++;
        if (ld_ack_cnt - lbase !== 1 || watch_cnt - wbase !== 1) begin
            failures++;
            $display("FAIL starve_single_write: acks=%0d writes=%0d required 1/1", ld_ack_cnt - lbase, watch_cnt - wbase);
        end
        checks++;
        if (mem[16'h3000] !== 8'h99) begin
            failures++;
            $display("FAIL starve_ld_data: got %h required 99", mem[16'h3000]);
        end
        $display("test_starve done");
    endtask

    task automatic test_overrun();
        int t0, cbase, wbase;
        do_reset();
        watch_addr = 16'h5555;
        step();
        cbase = cpu_ack_cnt; wbase = watch_cnt;
        t0 = cyc;
        bus.vdg_req = 1'b1; bus.vdg_addr = 16'h0100;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h5555; bus.cpu_din = 8'h11;
        step();
        bus.vdg_req = 1'b0;
        bus.cpu_addr = 16'h6666; bus.cpu_din = 8'h22;
        @(negedge clk);
        checks++;
        if (bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_early: got %b required 0", bus.overrun);
        end
        step();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        repeat (10) step();
        @(negedge clk);
        checks++;
        if (bus.overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_flag: got %b required 1", bus.overrun);
        end
        checks++;
        if (cpu_ack_cnt - cbase !== 1 || cpu_ack_cyc - t0 !== 6) begin
            failures++;
            $display("FAIL overrun_ack: acks=%0d lat=%0d required 1/6", cpu_ack_cnt - cbase, cpu_ack_cyc - t0);
        end
        checks++;
        if (watch_cnt - wbase !== 0 || mem[16'h6666] !== 8'h22) begin
            failures++;
            $display("FAIL overrun_replace: old_writes=%0d new_data=%h required 0/22", watch_cnt - wbase, mem[16'h6666]);
        end
        step();
        $display("test_overrun done");
    endtask

    task automatic test_reset_mid_access();
        int lat, n, cbase;
        do_reset();
        cpu_access(1'b0, 16'h0400, 8'h00, lat, n);
        cbase = cpu_ack_cnt;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h2000; bus.cpu_din = 8'h77;
        step();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 16'h2000) begin
            failures++;
            $display("FAIL midreset_access: we=%b addr=%h required 1/2000", bus.ram_we, bus.ram_addr);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 16'h0000 || bus.ram_din !== 8'h00) begin
            failures++;
            $display("FAIL midreset_ram: we=%b addr=%h din=%h required 0/0000/00", bus.ram_we, bus.ram_addr, bus.ram_din);
        end
        checks++;
        if (bus.cpu_dout !== 8'h00 || bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outs: cpu_dout=%h overrun=%b required 00/0", bus.cpu_dout, bus.overrun);
        end
        repeat (8) step();
        checks++;
        if (cpu_ack_cnt - cbase !== 0) begin
            failures++;
            $display("FAIL midreset_no_ack: acks=%0d required 0", cpu_ack_cnt - cbase);
        end
        $display("test_reset_mid_access done");
    endtask

    task automatic test_loader_readback();
        int iss [256];
        int nvdg, vbase, lat, maxlat;
        logic done;
        logic got;
        logic [7:0] rd;
        logic [7:0] exp_d;
        do_reset();
        done = 1'b0;
        nvdg = 0;
        vbase = vdg_ack_cnt;
        fork
            begin
                while (!done && nvdg < 256) begin
                    bus.vdg_req = 1'b1;
                    bus.vdg_addr = 16'h0400 + 16'(nvdg);
                    iss[nvdg] = cyc;
                    nvdg++;
                    step();
                    bus.vdg_req = 1'b0;
                    repeat (3) step();
                end
            end
            begin
                for (int i = 0; i < 16; i++) begin
                    bus.ld_addr = 16'hC000 + 16'(i);
                    bus.ld_din = 8'h50 + 8'(i);
                    bus.ld_req = 1'b1;
                    got = 1'b0;
                    for (int k = 0; k < 40 && !got; k++) begin
                        @(negedge clk);
                        if (bus.ld_ack) got = 1'b1;
                        step();
                    end
                    checks++;
                    if (!got) begin
                        failures++;
                        $display("FAIL ld_timeout: word %0d ack=0 required 1", i);
                    end
                end
                bus.ld_req = 1'b0;
                for (int i = 0; i < 16; i++) begin
                    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'hC000 + 16'(i);
                    step();
                    bus.cpu_req = 1'b0;
                    got = 1'b0;
                    rd = 8'h00;
                    for (int k = 0; k < 20 && !got; k++) begin
                        @(negedge clk);
                        if (bus.cpu_ack) begin got = 1'b1; rd = bus.cpu_dout; end
                        step();
                    end
                    exp_d = 8'h50 + 8'(i);
                    checks++;
                    if (!got || rd !== exp_d) begin
                        failures++;
                        $display("FAIL ld_readback: addr=%h ack=%b got %h required %h", 16'hC000 + 16'(i), got, rd, exp_d);
                    end
                end
                done = 1'b1;
            end
        join
        repeat (10) step();
        checks++;
        if (vdg_ack_cnt - vbase !== nvdg || nvdg < 10) begin
            failures++;
            $display("FAIL vdg_ack_count: acks=%0d required %0d (>=10)", vdg_ack_cnt - vbase, nvdg);
        end
        maxlat = 0;
        for (int k = 0; k < nvdg && (vbase + k) < 512; k++) begin
            lat = vdg_ack_log[vbase + k] - iss[k];
            if (lat > maxlat) maxlat = lat;
        end
        checks++;
        if (maxlat > 6 || maxlat < 4) begin
            failures++;
            $display("FAIL vdg_latency: max=%0d required 4..6", maxlat);
        end
        $display("test_loader_readback done: vdg reqs=%0d max latency=%0d", nvdg, maxlat);
    endtask

    initial begin
        reset = 1'b1;
        bus.vdg_req = 1'b0; bus.vdg_addr = 16'h0000;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_din = 8'h00;
        bus.ld_req = 1'b0; bus.ld_addr = 16'h0000; bus.ld_din = 8'h00;
        test_reset();
        test_cpu_write_read();
        test_vdg_cpu_same();
        test_starve();
        test_overrun();
        test_reset_mid_access();
        test_loader_readback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
